// File: rtl/readbuf_arb.sv
// Two-buffer read arbiter: grants one packet buffer at a time and streams it out as AXI-Stream beats.
// Optional build macro READBUF_ARB_PRIO_EN selects strict priority (channel 0 first) instead of round-robin.
module readbuf_arb #(
    parameter int MAX_BEATS = 1518,
    parameter int CNT_W     = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic greenflag0,
    input  logic greenflag1,
    input  logic lastflag0,
    input  logic lastflag1,
    input  logic tready,
    output logic tvalid,
    output logic tlast,
    output logic tsel,
    output logic rd_char_incr0,
    output logic rd_char_incr1,
    output logic rd_newline0,
    output logic rd_newline1,
    output logic trunc
);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             tsel_q;
    logic             grant;
    logic             any_green;
    logic             accept;
    logic             lastf;
    logic             forced;
    logic             term;

    assign any_green = greenflag0 | greenflag1;
    assign accept    = (state_q == READ) & tready;
    assign lastf     = tsel_q ? lastflag1 : lastflag0;
    assign forced    = (cnt_q == CNT_LAST);
    assign term      = accept & (lastf | forced);

`ifdef READBUF_ARB_PRIO_EN
    always_comb begin
        grant = ~greenflag0;
    end
`else
    logic last_q;

    // Contention goes to the channel that was not served most recently.
    always_comb begin
        if (greenflag0 && greenflag1) begin
            grant = ~last_q;
        end else begin
            grant = greenflag1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else if (term) begin
            last_q <= tsel_q;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (any_green) state_d = READ;
            READ: if (term)      state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // Grant is latched only in IDLE, so greenflag activity during READ never moves tsel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            tsel_q <= 1'b0;
        end else if (state_q == IDLE) begin
            if (any_green) begin
                cnt_q  <= '0;
                tsel_q <= grant;
            end
        end else if (accept) begin
            if (term) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        tvalid        = (state_q == READ);
        tlast         = term;
        tsel          = tsel_q;
        rd_char_incr0 = accept & ~term & ~tsel_q;
        rd_char_incr1 = accept & ~term &  tsel_q;
        rd_newline0   = term & ~tsel_q;
        rd_newline1   = term &  tsel_q;
        trunc         = term & forced & ~lastf;
    end

endmodule

// File: tb/tb_readbuf_arb.sv
// Bench for readbuf_arb: directed scenarios plus random traffic against a packet-level reference model.
module tb_readbuf_arb;

    localparam int MAXB = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic greenflag0 = 1'b0, greenflag1 = 1'b0;
    logic lastflag0 = 1'b0, lastflag1 = 1'b0;
    logic tready = 1'b0;
    logic tvalid, tlast, tsel, rd_char_incr0, rd_char_incr1;
    logic rd_newline0, rd_newline1, trunc;

    int n_checks = 0;
    int n_fail   = 0;

    readbuf_arb #(.MAX_BEATS(MAXB), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .greenflag0(greenflag0), .greenflag1(greenflag1),
        .lastflag0(lastflag0), .lastflag1(lastflag1),
        .tready(tready), .tvalid(tvalid), .tlast(tlast), .tsel(tsel),
        .rd_char_incr0(rd_char_incr0), .rd_char_incr1(rd_char_incr1),
        .rd_newline0(rd_newline0), .rd_newline1(rd_newline1), .trunc(trunc)
    );

    always #5 clk = ~clk;

    logic [7:0] obs;
    assign obs = {tvalid, tlast, tsel, rd_char_incr0, rd_char_incr1,
                  rd_newline0, rd_newline1, trunc};

    // Reference model: a packet in flight on channel m_ch with m_beats beats already delivered.
    bit   m_busy;
    bit   m_ch;
    int   m_beats;
    bit   m_ls;
    bit   grants[$];
    logic [7:0] exp_v;

    function automatic void model_reset();
        m_busy  = 0;
        m_ch    = 0;
        m_beats = 0;
        m_ls    = 1;
    endfunction

    function automatic logic [7:0] model_out();
        bit lf, frc, term;
        if (!rst) return 8'h00;
        if (!m_busy) return {2'b00, m_ch, 5'b00000};
        lf   = m_ch ? lastflag1 : lastflag0;
        frc  = (m_beats == MAXB - 1);
        term = tready && (lf || frc);
        return {1'b1, term, m_ch,
                tready && !term && !m_ch, tready && !term && m_ch,
                term && !m_ch, term && m_ch, term && frc && !lf};
    endfunction

    function automatic void model_step();
        bit lf, term;
        if (!rst) begin
            model_reset();
        end else if (!m_busy) begin
            if (greenflag0 || greenflag1) begin
`ifdef READBUF_ARB_PRIO_EN
                m_ch = !greenflag0;
`else
                m_ch = (greenflag0 && greenflag1) ? !m_ls : greenflag1;
`endif
                m_busy  = 1;
                m_beats = 0;
                grants.push_back(m_ch);
            end
        end else if (tready) begin
            lf   = m_ch ? lastflag1 : lastflag0;
            term = lf || (m_beats == MAXB - 1);
            if (term) begin
                m_busy  = 0;
                m_ls    = m_ch;
                m_beats = 0;
            end else begin
                m_beats++;
            end
        end
    endfunction

    task automatic drive(input bit g0, input bit g1, input bit l0, input bit l1, input bit tr);
        @(negedge clk);
        greenflag0 = g0; greenflag1 = g1;
        lastflag0  = l0; lastflag1  = l1;
        tready     = tr;
        #1;
        exp_v = model_out();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
    endtask

    task automatic test_reset();
        model_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1, 1, 1, 1, 1);
            n_checks++;
            if (obs !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_outputs got=%b exp=%b", obs, 8'h00);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        bit exp_g[4];
`ifdef READBUF_ARB_PRIO_EN
        exp_g = '{0, 0, 0, 0};
`else
        exp_g = '{0, 1, 0, 1};
`endif
        grants.delete();
        for (int c = 0; c < 30; c++) begin
            if (grants.size() == 4 && !m_busy) break;
            drive(1, 1, m_busy && m_beats == 3, m_busy && m_beats == 3, 1);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL rr_cycle c=%0d got=%b exp=%b", c, obs, exp_v);
            end
            tick();
        end
        n_checks++;
        if (grants.size() != 4) begin
            n_fail++;
            $display("FAIL rr_grant_count got=%0d exp=4", grants.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (grants[i] !== exp_g[i]) begin
                    n_fail++;
                    $display("FAIL rr_order i=%0d got=%0d exp=%0d", i, grants[i], exp_g[i]);
                end
            end
        end
    endtask

    task automatic test_single_packet();
        int  incr = 0;
        int  tl_at = -1;
        bit  tv1 = 0;
        for (int c = 0; c < 6; c++) begin
            drive(c == 0, 0, c == 4, 0, 1);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL single_cycle c=%0d got=%b exp=%b", c, obs, exp_v);
            end
            if (rd_char_incr0) incr++;
            if (tlast && rd_newline0) tl_at = c;
            if (c == 1) tv1 = tvalid;
            tick();
        end
        n_checks += 3;
        if (!tv1) begin
            n_fail++;
            $display("FAIL single_latency got=%0d exp=1", tv1);
        end
        if (incr != 3) begin
            n_fail++;
            $display("FAIL single_incr got=%0d exp=3", incr);
        end
        if (tl_at != 4) begin
            n_fail++;
            $display("FAIL single_tlast_cycle got=%0d exp=4", tl_at);
        end
    endtask

    task automatic test_tready_toggle();
        int incr = 0, nl = 0, bad = 0, k = 0;
        bit started = 0;
        for (int c = 0; c < 12; c++) begin
            bit tr;
            if (started && !m_busy) break;
            tr = !m_busy || (k % 2 == 0);
            drive(!started, 0, m_busy && m_beats == 2, 0, tr);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL toggle_cycle c=%0d got=%b exp=%b", c, obs, exp_v);
            end
            if (m_busy) begin
                k++;
                if (!tr && (obs[6] || obs[4:0] != 5'b00000)) bad++;
            end
            incr += int'(rd_char_incr0);
            nl   += int'(rd_newline0);
            if (m_busy) started = 1;
            tick();
            if (m_busy) started = 1;
        end
        n_checks += 3;
        if (incr != 2) begin
            n_fail++;
            $display("FAIL toggle_incr got=%0d exp=2", incr);
        end
        if (nl != 1) begin
            n_fail++;
            $display("FAIL toggle_newline got=%0d exp=1", nl);
        end
        if (bad != 0) begin
            n_fail++;
            $display("FAIL toggle_stall_pulses got=%0d exp=0", bad);
        end
    endtask

    // One packet on channel 0; lf_beat = beat index (1-based) carrying lastflag, 0 for never.
    task automatic run_trunc_pkt(input int lf_beat, input bit exp_trunc, input string nm);
        int  beat = 0, end_beat = -1;
        bit  tr_seen = 0;
        bit  started = 0;
        for (int c = 0; c < 20; c++) begin
            if (started && !m_busy) break;
            drive(!started, 0, m_busy && (m_beats + 1 == lf_beat), 0, 1);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL %s_cycle c=%0d got=%b exp=%b", nm, c, obs, exp_v);
            end
            if (tvalid) beat++;
            if (tlast && rd_newline0) begin
                end_beat = beat;
                tr_seen  = trunc;
            end
            tick();
            if (m_busy) started = 1;
        end
        n_checks += 2;
        if (end_beat != MAXB) begin
            n_fail++;
            $display("FAIL %s_end_beat got=%0d exp=%0d", nm, end_beat, MAXB);
        end
        if (tr_seen !== exp_trunc) begin
            n_fail++;
            $display("FAIL %s_trunc got=%0d exp=%0d", nm, tr_seen, exp_trunc);
        end
    endtask

    task automatic test_truncation();
        run_trunc_pkt(0, 1'b1, "trunc_forced");
        run_trunc_pkt(0, 1'b1, "trunc_again");
    endtask

    task automatic test_last_at_max();
        run_trunc_pkt(MAXB, 1'b0, "last_at_max");
    endtask

    task automatic test_reset_mid_packet();
        int nl1 = 0, nl0 = 0;
        bit started = 0;
        drive(1, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 1);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL midrst_before got=%b exp=%b", obs, exp_v);
        end
        #1 rst = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (obs !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_async got=%b exp=%b", obs, 8'h00);
        end
        tick();
        drive(0, 1, 0, 0, 1);
        n_checks++;
        if (obs !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_held got=%b exp=%b", obs, 8'h00);
        end
        tick();
        #2 rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (started && !m_busy) break;
            drive(!started, !started, 0, m_busy && m_beats == 1, 1);
            greenflag0 = 1'b0;
            #1;
            exp_v = model_out();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL midrst_pkt c=%0d got=%b exp=%b", c, obs, exp_v);
            end
            if (tvalid && tsel !== 1'b1) begin
                n_checks++;
                n_fail++;
                $display("FAIL midrst_tsel got=%0d exp=1", tsel);
            end
            nl1 += int'(rd_newline1);
            nl0 += int'(rd_newline0 | rd_char_incr0);
            tick();
            if (m_busy) started = 1;
        end
        n_checks++;
        if (nl1 != 1 || nl0 != 0) begin
            n_fail++;
            $display("FAIL midrst_newlines got=%0d/%0d exp=1/0", nl1, nl0);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) != 0);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL random c=%0d got=%b exp=%b", c, obs, exp_v);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_packet();
        test_tready_toggle();
        test_truncation();
        test_last_at_max();
        test_reset_mid_packet();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
